// File: rtl/fc_mac_seq.sv
// Sequential fully-connected layer: buffers one input vector, then computes
// OUT dot products against a weight ROM, one MAC per cycle.
module fc_mac_seq #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned IN    = 84,
  parameter  int unsigned OUT   = 10,
  localparam int unsigned ZW    = 2 * WIDTH + $clog2(IN),
  localparam int unsigned AW    = $clog2(OUT * IN),
  localparam int unsigned JW    = $clog2(OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             w_rd_o,
  output logic [AW-1:0]    w_addr_o,
  input  logic [WIDTH-1:0] w_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ZW-1:0]    out_data_o,
  output logic [JW-1:0]    out_idx_o,
  output logic             out_last_o
);

  localparam int unsigned CW = $clog2(IN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_FLUSH,
    S_OUT
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   i_q;
  logic [CW-1:0]   i_d1_q;
  logic            rd_d1_q;
  logic [JW-1:0]   j_q;
  logic [ZW-1:0]   acc_q;
  logic [ZW-1:0]   acc_d;
  logic [ZW-1:0]   prod_d;
  logic            in_ready_q;
  logic            w_rd_q;
  logic [AW-1:0]   w_addr_q;
  logic            out_valid_q;
  logic [ZW-1:0]   out_data_q;
  logic [JW-1:0]   out_idx_q;
  logic            out_last_q;
  logic [WIDTH-1:0] x_buf [IN];

  assign in_ready_o  = in_ready_q;
  assign w_rd_o      = w_rd_q;
  assign w_addr_o    = w_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;

  // Product of the weight returned this cycle with the activation it was read for.
  always_comb begin
    prod_d = ZW'(w_data_i) * ZW'(x_buf[i_d1_q]);
    acc_d  = acc_q;
    if (rd_d1_q) begin
      acc_d = acc_q + prod_d;
    end
  end

  // Activation buffer; fully rewritten before every use, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid_i && in_ready_q) begin
      x_buf[cnt_q] <= in_data_i;
    end
  end

  // Control FSM with registered outputs and the accumulator datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      i_d1_q      <= '0;
      rd_d1_q     <= 1'b0;
      j_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      w_rd_q      <= 1'b0;
      w_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rd_d1_q <= w_rd_q;
      i_d1_q  <= i_q;
      acc_q   <= acc_d;
      case (state_q)
        S_IDLE: begin
          state_q    <= S_LOAD;
          in_ready_q <= 1'b1;
        end
        S_LOAD: begin
          if (in_valid_i && in_ready_q) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(IN - 1)) begin
              state_q    <= S_MAC;
              in_ready_q <= 1'b0;
              i_q        <= '0;
              j_q        <= '0;
              w_rd_q     <= 1'b1;
              w_addr_q   <= '0;
              acc_q      <= '0;
            end
          end
        end
        S_MAC: begin
          if (i_q == CW'(IN - 1)) begin
            state_q  <= S_FLUSH;
            i_q      <= '0;
            w_rd_q   <= 1'b0;
            w_addr_q <= '0;
          end else begin
            i_q      <= i_q + CW'(1);
            w_addr_q <= w_addr_q + AW'(1);
          end
        end
        S_FLUSH: begin
          state_q     <= S_OUT;
          out_valid_q <= 1'b1;
          out_data_q  <= acc_d;
          out_idx_q   <= j_q;
          out_last_q  <= (j_q == JW'(OUT - 1));
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (j_q == JW'(OUT - 1)) begin
              state_q    <= S_LOAD;
              j_q        <= '0;
              cnt_q      <= '0;
              in_ready_q <= 1'b1;
            end else begin
              state_q  <= S_MAC;
              j_q      <= j_q + JW'(1);
              i_q      <= '0;
              w_rd_q   <= 1'b1;
              w_addr_q <= AW'((32'(j_q) + 32'd1) * IN);
              acc_q    <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_seq.sv
// Directed bench for fc_mac_seq with a registered weight ROM model.
module tb_fc_mac_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IN    = 84;
  localparam int unsigned OUT   = 10;
  localparam int unsigned ZW    = 23;
  localparam int unsigned AW    = 10;
  localparam int unsigned JW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             w_rd;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic             out_valid;
  logic             out_ready;
  logic [ZW-1:0]    out_data;
  logic [JW-1:0]    out_idx;
  logic             out_last;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ref_cyc  = 0;

  logic [7:0]  xv   [IN];
  logic [7:0]  rom  [1024];
  logic [31:0] expz [OUT];

  fc_mac_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .w_rd_o     (w_rd),
    .w_addr_o   (w_addr),
    .w_data_i   (w_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_idx_o  (out_idx),
    .out_last_o (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data one cycle after the read, junk otherwise.
  always @(posedge clk) w_data <= w_rd ? rom[w_addr] : 8'h77;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_out_valid"}, 32'(out_valid), 0);
    check({pfx, "_out_data"},  32'(out_data),  0);
    check({pfx, "_out_idx"},   32'(out_idx),   0);
    check({pfx, "_out_last"},  32'(out_last),  0);
    check({pfx, "_in_ready"},  32'(in_ready),  0);
    check({pfx, "_w_rd"},      32'(w_rd),      0);
    check({pfx, "_w_addr"},    32'(w_addr),    0);
  endtask

  task automatic fill_x(input int mode);
    for (int i = 0; i < IN; i++) begin
      case (mode)
        0:       xv[i] = 8'h00;
        1:       xv[i] = 8'hFF;
        2:       xv[i] = 8'h01;
        default: xv[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic fill_rom(input int mode);
    for (int a = 0; a < 1024; a++) begin
      if (a >= OUT * IN) rom[a] = 8'h00;
      else begin
        case (mode)
          0:       rom[a] = 8'h00;
          1:       rom[a] = 8'hFF;
          2:       rom[a] = 8'(a / IN + 1);
          default: rom[a] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic build_exp();
    for (int j = 0; j < OUT; j++) begin
      logic [31:0] s;
      s = 0;
      for (int i = 0; i < IN; i++) s += 32'(xv[i]) * 32'(rom[j * IN + i]);
      expz[j] = s;
    end
  endtask

  // Stream one vector; with gap=1 valid toggles and stays high afterwards.
  task automatic send(input bit gap);
    int k;
    int step;
    bit vld;
    bit acc;
    k = 0;
    step = 0;
    while (k < IN && step < 1000) begin
      vld      = gap ? (step % 2 == 0) : 1'b1;
      in_valid = vld;
      in_data  = vld ? xv[k] : 8'h5A;
      acc      = vld && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        ref_cyc = cyc;
      end
      step++;
    end
    in_valid = gap;
    in_data  = 8'hAA;
    check("send_accepts", k, IN);
  endtask

  // Consume n_out results, checking data, timing, addressing and stall behaviour.
  task automatic collect(input int n_out, input int bp_idx, input bit gap);
    for (int j = 0; j < n_out; j++) begin
      int exp_addr;
      int nrd;
      int bad_addr;
      int bad_ir;
      int t;
      int bad;
      logic [ZW-1:0] hold_d;
      logic [JW-1:0] hold_i;
      exp_addr = j * IN;
      nrd = 0;
      bad_addr = 0;
      bad_ir = 0;
      t = 0;
      while (out_valid !== 1'b1 && t < 500) begin
        if (w_rd === 1'b1) begin
          if (w_addr !== AW'(exp_addr)) bad_addr++;
          exp_addr++;
          nrd++;
        end
        if (in_ready !== 1'b0) bad_ir++;
        @(posedge clk); #1;
        t++;
      end
      check("out_valid_seen", 32'(out_valid), 1);
      check("latency", cyc - ref_cyc, IN + 1);
      check("rd_count", nrd, IN);
      check("addr_seq_errs", bad_addr, 0);
      check("in_ready_busy", bad_ir, 0);
      check("out_data", 32'(out_data), expz[j]);
      check("out_idx", 32'(out_idx), j);
      check("out_last", 32'(out_last), (j == OUT - 1) ? 1 : 0);
      if (j == bp_idx) begin
        hold_d = out_data;
        hold_i = out_idx;
        bad = 0;
        repeat (5) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b1 || out_data !== hold_d || out_idx !== hold_i ||
              w_rd !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        check("backpressure_hold", bad, 0);
      end
      if (j == OUT - 1 && gap) in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      ref_cyc = cyc;
      check("out_valid_drop", 32'(out_valid), 0);
    end
    if (n_out == OUT) check("in_ready_after_last", 32'(in_ready), 1);
  endtask

  initial begin
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    fill_rom(0);

    // Reset values, then one IDLE cycle before LOAD.
    #23;
    check_outputs_zero("reset");
    #4 rst_n = 1'b1;
    check("idle_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("load_in_ready", 32'(in_ready), 1);

    // All zeros.
    fill_x(0);
    fill_rom(0);
    for (int j = 0; j < OUT; j++) expz[j] = 32'h0;
    send(1'b0);
    collect(OUT, -1, 1'b0);

    // Maximum operands: 84 * 255 * 255.
    fill_x(1);
    fill_rom(1);
    for (int j = 0; j < OUT; j++) expz[j] = 32'h535854;
    send(1'b0);
    collect(OUT, -1, 1'b0);

    // Indexing: x=1, w[j][i]=j+1 gives 84*(j+1).
    fill_x(2);
    fill_rom(2);
    for (int j = 0; j < OUT; j++) expz[j] = 32'd84 * 32'(j + 1);
    send(1'b0);
    collect(OUT, -1, 1'b0);

    // Random operands with a 5-cycle stall on output 3.
    fill_x(3);
    fill_rom(3);
    build_exp();
    send(1'b0);
    collect(OUT, 3, 1'b0);

    // Same data with input gaps and in_valid held high while busy.
    send(1'b1);
    collect(OUT, -1, 1'b1);

    // Reset pulse at j=3, i=40, then a fresh vector.
    fill_x(3);
    build_exp();
    send(1'b0);
    collect(3, -1, 1'b0);
    t = 0;
    while (!(w_rd === 1'b1 && w_addr === AW'(3 * IN + 40)) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("mid_point_reached", 32'(w_addr), 3 * IN + 40);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    #3 rst_n = 1'b1;
    check("post_rst_idle", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("post_rst_load", 32'(in_ready), 1);
    fill_x(3);
    build_exp();
    send(1'b0);
    collect(OUT, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
